fifo_rd_packer: RTL

//  Read-side consumer for the team's FIFO read port (rinc/rempty/rdata).
//  - Drains WIDTH-bit entries whenever the FIFO is non-empty.
//  - Packs PACK consecutive entries into one WIDTH*PACK word.
//  - Presents each word downstream on a valid/ready handshake.
//  - Sits in the read clock domain, directly behind the FIFO.

---
 rtl/fifo_rd_packer_if.sv | 27 ++
 rtl/fifo_rd_packer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus the packed-word valid/ready stream of fifo_rd_packer.
// flush/out_keep are present only when FIFO_RD_PACKER_FLUSH_EN is defined.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 2
);
  logic                  rempty;
  logic [WIDTH-1:0]      rdata;
  logic                  rinc;
  logic                  out_ready;
  logic                  out_valid;
  logic [WIDTH*PACK-1:0] out_data;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                  flush;
  logic [PACK-1:0]       out_keep;

  modport master (input rempty, rdata, out_ready, flush,
                  output rinc, out_valid, out_data, out_keep);
  modport slave  (output rempty, rdata, out_ready, flush,
                  input rinc, out_valid, out_data, out_keep);
`else
  modport master (input rempty, rdata, out_ready,
                  output rinc, out_valid, out_data);
  modport slave  (output rempty, rdata, out_ready,
                  input rinc, out_valid, out_data);
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a FIFO read port and packs PACK entries into one valid/ready word.
// Optional partial-word flush with lane mask: define FIFO_RD_PACKER_FLUSH_EN.

module fifo_rd_packer_lane #(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 2
) (
  input  logic             rclk,
  input  logic             rrstn,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(PACK + 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                      r_state, w_state_nxt;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic                        r_pend;
  logic                        r_flush, w_flush_nxt;
  logic                        r_out_valid;
  logic [WIDTH*PACK-1:0]       r_out_data;
  logic [CW:0]                 w_sum;
  logic                        w_rinc, w_out_free, w_move;
  logic [PACK-1:0]             w_lane_we, w_keep;
  logic [PACK-1:0][WIDTH-1:0]  w_lane_q;
  logic [WIDTH*PACK-1:0]       w_word;

  // Entries already captured plus the one in flight must leave room in assembly.
  assign w_sum      = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_rinc     = rrstn && !bus.rempty && (r_state == FILL) && !r_flush &&
                      (w_sum < (CW+1)'(PACK));
  assign w_out_free = !r_out_valid || bus.out_ready;

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    assign w_lane_we[i] = r_pend && (r_cnt == CW'(i));
    assign w_keep[i]    = CW'(i) < r_cnt;
    // Unfilled lanes of a flushed word go out as zero.
    assign w_word[i*WIDTH +: WIDTH] = w_keep[i] ? w_lane_q[i] : '0;

    fifo_rd_packer_lane #(.WIDTH(WIDTH)) u_lane (
      .rclk (rclk),
      .rrstn(rrstn),
      .i_we (w_lane_we[i]),
      .i_d  (bus.rdata),
      .o_q  (w_lane_q[i])
    );
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_rinc;
      r_flush <= w_flush_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flush_nxt = r_flush;
    w_move      = 1'b0;
    case (r_state)
      FILL: begin
`ifdef FIFO_RD_PACKER_FLUSH_EN
        if (bus.flush && (r_cnt != '0 || r_pend)) w_flush_nxt = 1'b1;
`endif
        if (r_pend) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_nxt == CW'(PACK)) w_state_nxt = FULL;
        end else if (r_flush && w_out_free) begin
          w_move      = 1'b1;
          w_cnt_nxt   = '0;
          w_flush_nxt = 1'b0;
        end
      end
      FULL: begin
        if (w_out_free) begin
          w_move      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = FILL;
          w_flush_nxt = 1'b0;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_move) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic [PACK-1:0] r_out_keep;

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)      r_out_keep <= '0;
    else if (w_move) r_out_keep <= w_keep;
  end

  assign bus.out_keep = r_out_keep;
`endif

  assign bus.rinc      = w_rinc;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule
